sof_frame_generator: RTL and testbench

- Parametrised host-side start-of-frame engine; successor to the single-mode SOF controller.
- Owns the frame timer and the 11-bit frame number.
- In full-speed mode it transmits a complete 3-byte SOF token (PID, frame number, CRC5) over the host TX port arbitration handshake. In low-speed mode it issues a keep-alive EOP instead.
- Also gives the transaction scheduler an end-of-frame guard window and an overrun indication.

---
 rtl/sof_frame_generator.sv | 188 ++++++++++++++++++
 tb/tb_sof_frame_generator.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sof_frame_generator.sv
// sof_frame_generator: host start-of-frame engine. Runs the frame timer and
// frame number, and sends a full-speed SOF token or a low-speed keep-alive each frame.
`default_nettype none

module sof_frame_generator #(
  parameter int         TIMER_WIDTH    = 16,
  parameter int         FRAME_PERIOD   = 48000,
  parameter int         GUARD_CLKS     = 1500,
  parameter logic [7:0] CNTL_PKT_START = 8'h01,
  parameter logic [7:0] CNTL_PKT_DATA  = 8'h02,
  parameter logic [7:0] CNTL_PKT_STOP  = 8'h03,
  parameter logic [7:0] CNTL_LS_EOP    = 8'h04
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SOFEnable,
  input  logic                   FullSpeedMode,
  input  logic                   SOFTimerClr,
  input  logic                   HCTxPortGnt,
  input  logic                   HCTxPortRdy,
  output logic                   HCTxPortReq,
  output logic                   HCTxPortWEn,
  output logic [7:0]             HCTxPortData,
  output logic [7:0]             HCTxPortCntl,
  output logic [TIMER_WIDTH-1:0] SOFTimer,
  output logic [10:0]            FrameNum,
  output logic                   SOFSent,
  output logic                   SOFGuard,
  output logic                   SOFOverrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    WAIT_GNT  = 3'd2,
    WAIT_RDY  = 3'd3,
    WR        = 3'd4,
    CLR_WEN   = 3'd5,
    DONE      = 3'd6
  } stateT;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(FRAME_PERIOD - 1);
  localparam logic [TIMER_WIDTH-1:0] GUARD_START = TIMER_WIDTH'(FRAME_PERIOD - GUARD_CLKS);

  stateT                  state, stateNext;
  logic [TIMER_WIDTH-1:0] timerNext;
  logic [10:0]            frameNumNext;
  logic [10:0]            frameLatched, frameLatchedNext;
  logic                   fsLatched, fsLatchedNext;
  logic [1:0]             byteIdx, byteIdxNext;
  logic                   reqNext, wenNext, sentNext, overrunNext;
  logic [7:0]             dataNext, cntlNext;
  logic                   tick, lastByte;
  logic [4:0]             crcBits;

  // Register form of the USB CRC5, bit-reversed so crc5[0] is sent first.
  function automatic logic [4:0] crc5(input logic [10:0] value);
    logic [4:0] lfsr;
    logic [4:0] inv;
    lfsr = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (value[i] ^ lfsr[4]) lfsr = {lfsr[3:0], 1'b0} ^ 5'b00101;
      else                    lfsr = {lfsr[3:0], 1'b0};
    end
    inv = ~lfsr;
    return {inv[0], inv[1], inv[2], inv[3], inv[4]};
  endfunction

  assign crcBits  = crc5(frameLatched);
  assign tick     = SOFEnable && !SOFTimerClr && (state != IDLE) && (SOFTimer == TIMER_LAST);
  assign lastByte = fsLatched ? (byteIdx == 2'd2) : 1'b1;

  always_comb begin
    timerNext = SOFTimer;
    if (SOFTimerClr || !SOFEnable) timerNext = '0;
    else if (state == IDLE)        timerNext = SOFTimer;
    else if (tick)                 timerNext = '0;
    else                           timerNext = SOFTimer + TIMER_WIDTH'(1);
  end

  always_comb begin
    stateNext        = state;
    reqNext          = HCTxPortReq;
    wenNext          = 1'b0;
    dataNext         = HCTxPortData;
    cntlNext         = HCTxPortCntl;
    sentNext         = 1'b0;
    byteIdxNext      = byteIdx;
    fsLatchedNext    = fsLatched;
    frameLatchedNext = frameLatched;
    frameNumNext     = FrameNum;
    overrunNext      = tick && (state inside {WAIT_GNT, WAIT_RDY, WR, CLR_WEN});

    unique case (state)
      IDLE: begin
        if (SOFEnable) begin
          stateNext     = WAIT_GNT;
          reqNext       = 1'b1;
          fsLatchedNext = FullSpeedMode;
          byteIdxNext   = 2'd0;
        end
      end
      WAIT_TICK: begin
        if (!SOFEnable) begin
          stateNext = IDLE;
        end else if (tick) begin
          stateNext     = WAIT_GNT;
          reqNext       = 1'b1;
          fsLatchedNext = FullSpeedMode;
          byteIdxNext   = 2'd0;
        end
      end
      WAIT_GNT: begin
        if (HCTxPortGnt) begin
          stateNext        = WAIT_RDY;
          frameLatchedNext = FrameNum;
        end
      end
      WAIT_RDY: begin
        if (HCTxPortRdy) begin
          stateNext = WR;
          wenNext   = 1'b1;
          if (!fsLatched) begin
            dataNext = 8'h00;
            cntlNext = CNTL_LS_EOP;
          end else begin
            unique case (byteIdx)
              2'd0:    begin dataNext = 8'hA5;                        cntlNext = CNTL_PKT_START; end
              2'd1:    begin dataNext = frameLatched[7:0];            cntlNext = CNTL_PKT_DATA;  end
              default: begin dataNext = {crcBits, frameLatched[10:8]}; cntlNext = CNTL_PKT_STOP;  end
            endcase
          end
        end
      end
      WR: stateNext = CLR_WEN;
      CLR_WEN: begin
        if (!lastByte) begin
          stateNext   = WAIT_RDY;
          byteIdxNext = byteIdx + 2'd1;
        end else begin
          stateNext    = DONE;
          reqNext      = 1'b0;
          sentNext     = 1'b1;
          frameNumNext = FrameNum + 11'd1;
        end
      end
      DONE:    stateNext = SOFEnable ? WAIT_TICK : IDLE;
      default: stateNext = IDLE;
    endcase

    if (SOFTimerClr) frameNumNext = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      SOFTimer     <= '0;
      FrameNum     <= '0;
      HCTxPortReq  <= 1'b0;
      HCTxPortWEn  <= 1'b0;
      HCTxPortData <= 8'h00;
      HCTxPortCntl <= 8'h00;
      SOFSent      <= 1'b0;
      SOFGuard     <= 1'b0;
      SOFOverrun   <= 1'b0;
      byteIdx      <= 2'd0;
      fsLatched    <= 1'b0;
      frameLatched <= '0;
    end else begin
      state        <= stateNext;
      SOFTimer     <= timerNext;
      FrameNum     <= frameNumNext;
      HCTxPortReq  <= reqNext;
      HCTxPortWEn  <= wenNext;
      HCTxPortData <= dataNext;
      HCTxPortCntl <= cntlNext;
      SOFSent      <= sentNext;
      SOFGuard     <= (timerNext >= GUARD_START);
      SOFOverrun   <= overrunNext;
      byteIdx      <= byteIdxNext;
      fsLatched    <= fsLatchedNext;
      frameLatched <= frameLatchedNext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sof_frame_generator.sv
// tb_sof_frame_generator: randomized self-checking bench for sof_frame_generator
// against a packet-level reference model of the SOF/keep-alive traffic.
`default_nettype none

module tb_sof_frame_generator;

  localparam int FP     = 100;
  localparam int GUARD  = 20;
  localparam int FP2    = 16;
  localparam int GUARD2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, SOFEnable, FullSpeedMode, SOFTimerClr;
  logic        gntForce, rdyForce, stallMode, gntRand, rdyRand;
  logic        HCTxPortGnt, HCTxPortRdy;
  logic        HCTxPortReq, HCTxPortWEn, SOFSent, SOFGuard, SOFOverrun;
  logic [7:0]  HCTxPortData, HCTxPortCntl;
  logic [15:0] SOFTimer;
  logic [10:0] FrameNum;

  logic        rst2, en2;
  logic        Req2, WEn2, Sent2, Guard2, Ovr2;
  logic [7:0]  Data2, Cntl2;
  logic [15:0] Timer2;
  logic [10:0] FrameNum2;

  assign HCTxPortGnt = stallMode ? gntRand : gntForce;
  assign HCTxPortRdy = stallMode ? rdyRand : rdyForce;

  sof_frame_generator #(.TIMER_WIDTH(16), .FRAME_PERIOD(FP), .GUARD_CLKS(GUARD)) dut (
    .clk(clk), .rst(rst), .SOFEnable(SOFEnable), .FullSpeedMode(FullSpeedMode),
    .SOFTimerClr(SOFTimerClr), .HCTxPortGnt(HCTxPortGnt), .HCTxPortRdy(HCTxPortRdy),
    .HCTxPortReq(HCTxPortReq), .HCTxPortWEn(HCTxPortWEn), .HCTxPortData(HCTxPortData),
    .HCTxPortCntl(HCTxPortCntl), .SOFTimer(SOFTimer), .FrameNum(FrameNum),
    .SOFSent(SOFSent), .SOFGuard(SOFGuard), .SOFOverrun(SOFOverrun)
  );

  sof_frame_generator #(.TIMER_WIDTH(16), .FRAME_PERIOD(FP2), .GUARD_CLKS(GUARD2)) dutWrap (
    .clk(clk), .rst(rst2), .SOFEnable(en2), .FullSpeedMode(1'b1),
    .SOFTimerClr(1'b0), .HCTxPortGnt(1'b1), .HCTxPortRdy(1'b1),
    .HCTxPortReq(Req2), .HCTxPortWEn(WEn2), .HCTxPortData(Data2),
    .HCTxPortCntl(Cntl2), .SOFTimer(Timer2), .FrameNum(FrameNum2),
    .SOFSent(Sent2), .SOFGuard(Guard2), .SOFOverrun(Ovr2)
  );

  int          checks = 0;
  int          passes = 0;
  int          cycle = 0;
  int          sentCnt = 0;
  int          ovrCnt = 0;
  logic        prevReq = 1'b0;
  logic [15:0] wrQ[$];
  logic [15:0] wrQ2[$];
  int          reqRise[$];
  int          frame0Rise;
  logic [10:0] expFrame;

  always @(negedge clk) begin
    cycle++;
    if (HCTxPortWEn) wrQ.push_back({HCTxPortData, HCTxPortCntl});
    if (WEn2) wrQ2.push_back({Data2, Cntl2});
    if (SOFSent) sentCnt++;
    if (SOFOverrun) ovrCnt++;
    if (HCTxPortReq && !prevReq) reqRise.push_back(cycle);
    prevReq = HCTxPortReq;
  end

  always @(negedge clk) begin
    gntRand = ($urandom_range(0, 3) != 0);
    rdyRand = ($urandom_range(0, 3) != 0);
  end

  // Reference CRC5 in reflected (transmit-order) form.
  function automatic logic [4:0] refCrc5(input logic [10:0] f);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) r = (f[i] ^ r[0]) ? ((r >> 1) ^ 5'b10100) : (r >> 1);
    return ~r;
  endfunction

  // Expected {data, cntl} of write i of the packet for frame f.
  function automatic logic [15:0] refWrite(input logic [10:0] f, input bit fs, input int i);
    if (!fs) return 16'h0004;
    case (i)
      0:       return 16'hA501;
      1:       return {f[7:0], 8'h02};
      default: return {refCrc5(f), f[10:8], 8'h03};
    endcase
  endfunction

  function automatic logic [15:0] wrAt(input int idx);
    return (idx < wrQ.size()) ? wrQ[idx] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] wrAt2(input int idx);
    return (idx < wrQ2.size()) ? wrQ2[idx] : 16'hxxxx;
  endfunction

  task automatic waitSent(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc && !ok; i++) begin
      @(negedge clk);
      if (SOFSent) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rst2 = 1'b0; en2 = 1'b0;
    SOFEnable = 1'b0; FullSpeedMode = 1'b0; SOFTimerClr = 1'b0;
    gntForce = 1'b0; rdyForce = 1'b0; stallMode = 1'b0;
    repeat (3) @(negedge clk);
    SOFEnable = 1'b1; FullSpeedMode = 1'b1; gntForce = 1'b1; rdyForce = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({HCTxPortReq, HCTxPortWEn, SOFSent, SOFGuard, SOFOverrun} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000",
               {HCTxPortReq, HCTxPortWEn, SOFSent, SOFGuard, SOFOverrun});
    else passes++;
    checks++;
    if ({HCTxPortData, HCTxPortCntl} !== 16'h0000)
      $display("FAIL reset_data_cntl: got %h expected 0000", {HCTxPortData, HCTxPortCntl});
    else passes++;
    checks++;
    if (SOFTimer !== 16'd0) $display("FAIL reset_timer: got %0d expected 0", SOFTimer);
    else passes++;
    checks++;
    if (FrameNum !== 11'd0) $display("FAIL reset_framenum: got %0d expected 0", FrameNum);
    else passes++;
  endtask

  task automatic test_first_sof();
    int  base;
    bit  ok;
    base = wrQ.size();
    frame0Rise = reqRise.size();
    rst = 1'b1;
    waitSent(40, ok);
    checks++;
    if (!ok) $display("FAIL first_sof_sent: got no SOFSent expected pulse within 40 cycles");
    else passes++;
    checks++;
    if (wrQ.size() - base !== 3) $display("FAIL first_sof_count: got %0d expected 3", wrQ.size() - base);
    else passes++;
    checks++;
    if ({wrAt(base), wrAt(base + 1), wrAt(base + 2)} !== {16'hA501, 16'h0002, 16'h1003})
      $display("FAIL first_sof_bytes: got %h %h %h expected a501 0002 1003",
               wrAt(base), wrAt(base + 1), wrAt(base + 2));
    else passes++;
    checks++;
    if (FrameNum !== 11'd1) $display("FAIL first_sof_framenum: got %0d expected 1", FrameNum);
    else passes++;
    expFrame = 11'd1;
  endtask

  task automatic test_frame_timing();
    int   base, prevT, sents, riseT;
    bit   tOk, gOk;
    logic prevGuard;
    base = wrQ.size(); prevT = -1; sents = 0; riseT = -1; tOk = 1'b1; gOk = 1'b1;
    prevGuard = SOFGuard;
    for (int i = 0; i < 260 && sents < 2; i++) begin
      @(negedge clk);
      if (prevT >= 0 && tOk && SOFTimer !== 16'((prevT == FP - 1) ? 0 : prevT + 1)) begin
        $display("FAIL timer_step: got %0d expected %0d", SOFTimer, (prevT == FP - 1) ? 0 : prevT + 1);
        tOk = 1'b0;
      end
      if (gOk && SOFGuard !== (SOFTimer >= 16'(FP - GUARD))) begin
        $display("FAIL guard_level: got %b expected %b at timer %0d",
                 SOFGuard, SOFTimer >= 16'(FP - GUARD), SOFTimer);
        gOk = 1'b0;
      end
      if (SOFGuard && !prevGuard && riseT < 0) riseT = int'(SOFTimer);
      prevGuard = SOFGuard;
      prevT = int'(SOFTimer);
      if (SOFSent) sents++;
    end
    checks++; if (!tOk) ; else passes++;
    checks++; if (!gOk) ; else passes++;
    checks++;
    if (sents != 2) $display("FAIL timing_frames: got %0d SOFs expected 2", sents);
    else passes++;
    checks++;
    if (riseT != FP - GUARD) $display("FAIL guard_rise: got timer %0d expected %0d", riseT, FP - GUARD);
    else passes++;
    checks++;
    if (reqRise.size() < frame0Rise + 3 ||
        reqRise[frame0Rise + 1] - reqRise[frame0Rise] != FP ||
        reqRise[frame0Rise + 2] - reqRise[frame0Rise + 1] != FP)
      $display("FAIL sof_spacing: got %0d rises expected 3 spaced %0d", reqRise.size() - frame0Rise, FP);
    else passes++;
    checks++;
    if (wrAt(base + 2) !== 16'hE803) $display("FAIL frame1_crc: got %h expected e803", wrAt(base + 2));
    else passes++;
    checks++;
    if (wrAt(base + 5) !== refWrite(11'd2, 1'b1, 2))
      $display("FAIL frame2_crc: got %h expected %h", wrAt(base + 5), refWrite(11'd2, 1'b1, 2));
    else passes++;
    checks++;
    if (FrameNum !== 11'd3) $display("FAIL timing_framenum: got %0d expected 3", FrameNum);
    else passes++;
    expFrame = 11'd3;
  endtask

  task automatic test_random_frames();
    int base, ovrBase, n;
    bit ok, mode;
    ovrBase = ovrCnt;
    stallMode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      mode = 1'($urandom_range(0, 1));
      FullSpeedMode = mode;
      base = wrQ.size();
      waitSent(300, ok);
      n = mode ? 3 : 1;
      checks++;
      if (!ok || wrQ.size() - base != n)
        $display("FAIL rand_count: got %0d writes (sent=%0b) expected %0d", wrQ.size() - base, ok, n);
      else passes++;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wrAt(base + i) !== refWrite(expFrame, mode, i))
          $display("FAIL rand_write: frame %0d byte %0d got %h expected %h",
                   expFrame, i, wrAt(base + i), refWrite(expFrame, mode, i));
        else passes++;
      end
      checks++;
      if (FrameNum !== expFrame + 11'd1)
        $display("FAIL rand_framenum: got %0d expected %0d", FrameNum, expFrame + 11'd1);
      else passes++;
      expFrame = expFrame + 11'd1;
    end
    stallMode = 1'b0;
    checks++;
    if (ovrCnt != ovrBase) $display("FAIL rand_no_overrun: got %0d expected 0", ovrCnt - ovrBase);
    else passes++;
  endtask

  task automatic test_low_speed();
    int base;
    bit ok;
    FullSpeedMode = 1'b0;
    base = wrQ.size();
    waitSent(150, ok);
    checks++;
    if (!ok || wrQ.size() - base != 1 || wrAt(base) !== 16'h0004)
      $display("FAIL ls_packet: got %0d writes first %h expected 1 write 0004", wrQ.size() - base, wrAt(base));
    else passes++;
    checks++;
    if (FrameNum !== expFrame + 11'd1) $display("FAIL ls_framenum: got %0d expected %0d", FrameNum, expFrame + 11'd1);
    else passes++;
    expFrame = expFrame + 11'd1;
    FullSpeedMode = 1'b1;
  endtask

  task automatic test_overrun();
    int base, ovrBase;
    bit ok;
    gntForce = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      @(negedge clk);
      if (HCTxPortReq) ok = 1'b1;
    end
    checks++;
    if (!ok) $display("FAIL ovr_req: got no request expected one within 150 cycles");
    else passes++;
    ovrBase = ovrCnt;
    base = wrQ.size();
    repeat (250) @(negedge clk);
    checks++;
    if (ovrCnt - ovrBase != 2) $display("FAIL ovr_pulses: got %0d expected 2", ovrCnt - ovrBase);
    else passes++;
    checks++;
    if (wrQ.size() != base) $display("FAIL ovr_no_write: got %0d expected 0", wrQ.size() - base);
    else passes++;
    gntForce = 1'b1;
    waitSent(50, ok);
    checks++;
    if (!ok || wrQ.size() - base != 3 || wrAt(base + 1) !== refWrite(expFrame, 1'b1, 1) ||
        wrAt(base + 2) !== refWrite(expFrame, 1'b1, 2))
      $display("FAIL ovr_packet: got %0d writes %h %h expected 3 writes %h %h", wrQ.size() - base,
               wrAt(base + 1), wrAt(base + 2), refWrite(expFrame, 1'b1, 1), refWrite(expFrame, 1'b1, 2));
    else passes++;
    checks++;
    if (FrameNum !== expFrame + 11'd1) $display("FAIL ovr_framenum: got %0d expected %0d", FrameNum, expFrame + 11'd1);
    else passes++;
    expFrame = expFrame + 11'd1;
  endtask

  task automatic test_clear();
    int base, n;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      @(negedge clk);
      if (SOFTimer == 16'd50) ok = 1'b1;
    end
    SOFTimerClr = 1'b1;
    @(negedge clk);
    SOFTimerClr = 1'b0;
    checks++;
    if (!ok || SOFTimer !== 16'd0 || FrameNum !== 11'd0)
      $display("FAIL clear: got timer %0d frame %0d expected 0 0", SOFTimer, FrameNum);
    else passes++;
    base = wrQ.size();
    n = 0;
    while (!HCTxPortReq && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != FP) $display("FAIL clear_next_sof: got %0d cycles expected %0d", n, FP);
    else passes++;
    waitSent(40, ok);
    checks++;
    if (!ok || {wrAt(base), wrAt(base + 1), wrAt(base + 2)} !== {16'hA501, 16'h0002, 16'h1003})
      $display("FAIL clear_packet: got %h %h %h expected a501 0002 1003", wrAt(base), wrAt(base + 1), wrAt(base + 2));
    else passes++;
    expFrame = 11'd1;
  endtask

  task automatic test_async_reset();
    int base;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      @(negedge clk);
      if (HCTxPortWEn) ok = 1'b1;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (!ok || {HCTxPortReq, HCTxPortWEn, SOFSent, SOFGuard, SOFOverrun} !== 5'b0 ||
        {HCTxPortData, HCTxPortCntl} !== 16'h0000 || SOFTimer !== 16'd0 || FrameNum !== 11'd0)
      $display("FAIL async_reset: got req %b wen %b data %h cntl %h timer %0d frame %0d expected all 0",
               HCTxPortReq, HCTxPortWEn, HCTxPortData, HCTxPortCntl, SOFTimer, FrameNum);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    base = wrQ.size();
    waitSent(40, ok);
    checks++;
    if (!ok || wrQ.size() - base != 3 || wrAt(base + 1) !== 16'h0002 || FrameNum !== 11'd1)
      $display("FAIL after_reset_packet: got %0d writes byte1 %h frame %0d expected 3 0002 1",
               wrQ.size() - base, wrAt(base + 1), FrameNum);
    else passes++;
  endtask

  task automatic test_wrap();
    int base;
    int ovr2;
    bit found, g2Ok, ok;
    found = 1'b0; g2Ok = 1'b1; ovr2 = 0;
    rst2 = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < FP2 * 2047 + 200 && !found; i++) begin
      @(negedge clk);
      if (g2Ok && Guard2 !== (Timer2 >= 16'(FP2 - GUARD2))) begin
        $display("FAIL wrap_guard: got %b at timer %0d", Guard2, Timer2);
        g2Ok = 1'b0;
      end
      if (Ovr2) ovr2++;
      if (FrameNum2 == 11'd2047) found = 1'b1;
    end
    checks++;
    if (!found || ovr2 != 0 || !g2Ok)
      $display("FAIL wrap_reach_2047: got frame %0d overruns %0d expected 2047 0", FrameNum2, ovr2);
    else passes++;
    base = wrQ2.size();
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (Sent2) ok = 1'b1;
    end
    checks++;
    if (!ok || wrQ2.size() - base != 3 || wrAt2(base + 1) !== 16'hFF02)
      $display("FAIL wrap_byte1: got %0d writes byte1 %h expected 3 ff02", wrQ2.size() - base, wrAt2(base + 1));
    else passes++;
    checks++;
    if (wrAt2(base + 2) !== refWrite(11'd2047, 1'b1, 2))
      $display("FAIL wrap_byte2: got %h expected %h", wrAt2(base + 2), refWrite(11'd2047, 1'b1, 2));
    else passes++;
    checks++;
    if (FrameNum2 !== 11'd0 || Req2 !== 1'b0)
      $display("FAIL wrap_framenum: got frame %0d req %b expected 0 0", FrameNum2, Req2);
    else passes++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_sof();
    test_frame_timing();
    test_random_frames();
    test_low_speed();
    test_overrun();
    test_clear();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
